// File: rtl/coin_acceptor.sv
// ============================================================================
// coin_acceptor : synchronizes and debounces three coin/pay switches and
// issues prioritized, spaced one-cycle pulses to the vending core.
// Revision 1.0
// ============================================================================
`default_nettype none

module coin_acceptor #(
  parameter int DB_CYC = 4,
  parameter int GAP    = 2
) (
  input  logic ck,
  input  logic reset,
  input  logic raw5,
  input  logic raw10,
  input  logic rawpay,
  output logic co5,
  output logic co10,
  output logic pay,
  output logic busy,
  output logic ovr
);

  localparam logic [3:0] C_DB  = 4'(DB_CYC);
  localparam logic [2:0] C_GAP = 3'(GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Bit order everywhere: [0]=5-unit, [1]=10-unit, [2]=pay (also priority order).
  logic [2:0] w_raw;
  logic [2:0] r_sync1, r_sync2;
  logic [2:0] w_deb;
  logic [2:0] r_deb_d;
  logic [2:0] w_rise;
  logic [2:0] w_issue;
  logic [2:0] w_pick;
  logic [2:0] r_pend;
  logic       r_ovr;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_sel, w_sel_nxt;
  logic [2:0] r_gap, w_gap_nxt;

  assign w_raw = {rawpay, raw10, raw5};

  for (genvar gi = 0; gi < 3; gi++) begin : g_src
    logic [3:0] r_cnt;
    logic       r_deb;

    always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
        r_cnt <= 4'd0;
        r_deb <= 1'b0;
      end else if (r_sync2[gi] == r_deb) begin
        r_cnt <= 4'd0;
      end else if (r_cnt + 4'd1 == C_DB) begin
        r_deb <= r_sync2[gi];
        r_cnt <= 4'd0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end

    assign w_deb[gi] = r_deb;
  end

  assign w_rise  = w_deb & ~r_deb_d;
  assign w_issue = (r_state == S_PULSE) ? r_sel : 3'b000;
  assign w_pick  = r_pend[0] ? 3'b001 :
                   r_pend[1] ? 3'b010 :
                   r_pend[2] ? 3'b100 : 3'b000;

  // A rise coinciding with the issue of the same source re-arms it instead of overrunning.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_deb_d <= 3'b000;
      r_pend  <= 3'b000;
      r_ovr   <= 1'b0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= w_deb;
      r_pend  <= (r_pend & ~w_issue) | w_rise;
      if (|(w_rise & r_pend & ~w_issue)) begin
        r_ovr <= 1'b1;
      end
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sel   <= 3'b000;
      r_gap   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_gap_nxt   = r_gap;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_state_nxt = S_PULSE;
          w_sel_nxt   = w_pick;
        end
      end
      S_PULSE: begin
        w_gap_nxt   = C_GAP;
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        w_gap_nxt = r_gap - 3'd1;
        // Final gap cycle makes the idle decision itself so pulses are GAP+1 apart.
        if (r_gap == 3'd1) begin
          if (|r_pend) begin
            w_state_nxt = S_PULSE;
            w_sel_nxt   = w_pick;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign {pay, co10, co5} = w_issue;
  assign busy = (|r_pend) | (r_state != S_IDLE);
  assign ovr  = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_coin_acceptor.sv
// ============================================================================
// tb_coin_acceptor : scenario tasks plus randomized traffic, compared against a
// time-based behavioural model of debounce windows and the pulse issuer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_coin_acceptor;

  localparam int DB = 4;
  localparam int GP = 2;
  localparam logic [15:0] C_MASK = 16'((1 << DB) - 1);

  logic ck = 1'b0;
  logic reset;
  logic raw5, raw10, rawpay;
  logic co5, co10, pay, busy, ovr;
  logic raw5_7, raw10_7, rawpay_7;
  logic co5_7, co10_7, pay_7, busy_7, ovr_7;

  int n_cmp = 0;
  int n_err = 0;

  always #10 ck = ~ck;

  coin_acceptor #(.DB_CYC(DB), .GAP(GP)) u_dut (
    .ck(ck), .reset(reset), .raw5(raw5), .raw10(raw10), .rawpay(rawpay),
    .co5(co5), .co10(co10), .pay(pay), .busy(busy), .ovr(ovr)
  );

  coin_acceptor #(.DB_CYC(DB), .GAP(7)) u_dut7 (
    .ck(ck), .reset(reset), .raw5(raw5_7), .raw10(raw10_7), .rawpay(rawpay_7),
    .co5(co5_7), .co10(co10_7), .pay(pay_7), .busy(busy_7), .ovr(ovr_7)
  );

  // ---------------- reference model ----------------
  // Debounce: level flips once the last DB synchronized samples all disagree with it.
  // Issuer: a decision may be taken in any cycle at least GAP cycles after the last pulse.
  logic [2:0]  m_raw;
  logic [2:0]  m_rawq, m_deb, m_rise, m_pend;
  logic [15:0] m_hist [3];
  logic        m_ovr;
  logic [1:0]  m_pulse;
  int          m_cyc, m_last;
  logic [1:0]  n_pulse;
  logic [2:0]  n_pend, n_lost, n_flip;
  logic [4:0]  m_exp;

  assign m_raw = {rawpay, raw10, raw5};

  always_comb begin
    n_pulse = 2'd0;
    n_pend  = 3'b000;
    n_lost  = 3'b000;
    n_flip  = 3'b000;
    if (m_cyc >= m_last + GP && |m_pend)
      n_pulse = m_pend[0] ? 2'd1 : (m_pend[1] ? 2'd2 : 2'd3);
    for (int s = 0; s < 3; s++) begin
      n_pend[s] = m_rise[s] | (m_pend[s] & (m_pulse != 2'(s + 1)));
      n_lost[s] = m_rise[s] & m_pend[s] & (m_pulse != 2'(s + 1));
      n_flip[s] = m_deb[s] ? ((m_hist[s] & C_MASK) == 16'd0)
                           : ((m_hist[s] & C_MASK) == C_MASK);
    end
  end

  always @(posedge ck or negedge reset) begin
    if (!reset) begin
      m_rawq  <= 3'b000;
      m_deb   <= 3'b000;
      m_rise  <= 3'b000;
      m_pend  <= 3'b000;
      m_ovr   <= 1'b0;
      m_pulse <= 2'd0;
      m_cyc   <= 0;
      m_last  <= -100;
      for (int s = 0; s < 3; s++) m_hist[s] <= 16'd0;
    end else begin
      m_cyc   <= m_cyc + 1;
      m_pulse <= n_pulse;
      if (n_pulse != 2'd0) m_last <= m_cyc + 1;
      m_pend  <= n_pend;
      m_ovr   <= m_ovr | (|n_lost);
      m_rise  <= n_flip & ~m_deb;
      m_deb   <= m_deb ^ n_flip;
      for (int s = 0; s < 3; s++) m_hist[s] <= {m_hist[s][14:0], m_rawq[s]};
      m_rawq  <= m_raw;
    end
  end

  assign m_exp = {m_pulse == 2'd1, m_pulse == 2'd2, m_pulse == 2'd3,
                  (|m_pend) || (m_cyc <= m_last + GP), m_ovr};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    raw5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      n_cmp++;
      if ({co5, co10, pay, busy, ovr} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=00000", i, {co5, co10, pay, busy, ovr});
      end
    end
  endtask

  task automatic test_release_latency();
    int first = -1;
    int cnt5 = 0;
    int cnt_other = 0;
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge ck);
      n_cmp++;
      if ({co5, co10, pay, busy, ovr} !== m_exp) begin
        n_err++;
        $display("FAIL release_model cyc=%0d got=%b exp=%b", i, {co5, co10, pay, busy, ovr}, m_exp);
      end
      if (co5 === 1'b1) begin
        cnt5++;
        if (first < 0) first = i;
      end
      if (co10 === 1'b1 || pay === 1'b1) cnt_other++;
      if (i == 5) raw5 = 1'b0;
    end
    n_cmp++;
    if (first != DB + 4) begin
      n_err++;
      $display("FAIL release_latency got=%0d exp=%0d", first, DB + 4);
    end
    n_cmp++;
    if (cnt5 != 1 || cnt_other != 0) begin
      n_err++;
      $display("FAIL release_count co5=%0d other=%0d exp 1/0", cnt5, cnt_other);
    end
  endtask

  task automatic test_bounce();
    int cnt10 = 0;
    for (int i = 0; i < 24; i++) begin
      raw10 = (i < 3) ? ~raw10 : 1'b0;
      @(negedge ck);
      n_cmp++;
      if ({co5, co10, pay, busy, ovr} !== m_exp) begin
        n_err++;
        $display("FAIL bounce_model cyc=%0d got=%b exp=%b", i, {co5, co10, pay, busy, ovr}, m_exp);
      end
      if (co10 === 1'b1) cnt10++;
    end
    n_cmp++;
    if (cnt10 != 0 || ovr !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_nopulse co10=%0d ovr=%b exp 0/0", cnt10, ovr);
    end
  endtask

  task automatic test_simultaneous();
    int t5 = -1;
    int t10 = -1;
    raw5  = 1'b1;
    raw10 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 5) begin
        raw5  = 1'b0;
        raw10 = 1'b0;
      end
      @(negedge ck);
      n_cmp++;
      if ({co5, co10, pay, busy, ovr} !== m_exp) begin
        n_err++;
        $display("FAIL simul_model cyc=%0d got=%b exp=%b", i, {co5, co10, pay, busy, ovr}, m_exp);
      end
      if (co5 === 1'b1 && t5 < 0) t5 = i;
      if (co10 === 1'b1 && t10 < 0) t10 = i;
    end
    n_cmp++;
    if (t5 < 0 || t10 - t5 != GP + 1) begin
      n_err++;
      $display("FAIL simul_spacing co5@%0d co10@%0d exp spacing %0d", t5, t10, GP + 1);
    end
  endtask

  task automatic test_sequence();
    int order[$];
    int src[4] = '{0, 1, 1, 2};
    for (int e = 0; e < 4; e++) begin
      for (int i = 0; i < 10; i++) begin
        raw5   = (i < 5) && (src[e] == 0);
        raw10  = (i < 5) && (src[e] == 1);
        rawpay = (i < 5) && (src[e] == 2);
        @(negedge ck);
        n_cmp++;
        if ({co5, co10, pay, busy, ovr} !== m_exp) begin
          n_err++;
          $display("FAIL seq_model ev=%0d cyc=%0d got=%b exp=%b", e, i, {co5, co10, pay, busy, ovr}, m_exp);
        end
        if (co5 === 1'b1)  order.push_back(0);
        if (co10 === 1'b1) order.push_back(1);
        if (pay === 1'b1)  order.push_back(2);
      end
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge ck);
      if (co5 === 1'b1)  order.push_back(0);
      if (co10 === 1'b1) order.push_back(1);
      if (pay === 1'b1)  order.push_back(2);
    end
    n_cmp++;
    if (order.size() != 4) begin
      n_err++;
      $display("FAIL seq_count got=%0d exp=4", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (order[k] != src[k]) begin
          n_err++;
          $display("FAIL seq_order idx=%0d got=%0d exp=%0d", k, order[k], src[k]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    int late = 0;
    raw5  = 1'b1;
    raw10 = 1'b1;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      if (i == 5) begin
        raw5  = 1'b0;
        raw10 = 1'b0;
      end
      @(negedge ck);
      if (co5 === 1'b1) seen = 1;
    end
    raw5  = 1'b0;
    raw10 = 1'b0;
    n_cmp++;
    if (seen == 0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_setup co5_seen=%0d busy=%b exp 1/1", seen, busy);
    end
    @(negedge ck);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({co5, co10, pay, busy, ovr} !== 5'b0) begin
      n_err++;
      $display("FAIL abort_inreset got=%b exp=00000", {co5, co10, pay, busy, ovr});
    end
    repeat (3) @(negedge ck);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge ck);
      n_cmp++;
      if ({co5, co10, pay, busy, ovr} !== m_exp) begin
        n_err++;
        $display("FAIL abort_model cyc=%0d got=%b exp=%b", i, {co5, co10, pay, busy, ovr}, m_exp);
      end
      if (co10 === 1'b1 || busy === 1'b1) late++;
    end
    n_cmp++;
    if (late != 0) begin
      n_err++;
      $display("FAIL abort_nopulse busy_or_co10_cycles=%0d exp=0", late);
    end
  endtask

  task automatic test_overrun();
    int set_at = -1;
    int dropped = 0;
    int both = 0;
    for (int i = 0; i < 140; i++) begin
      raw5_7  = (i % 10) < 5;
      raw10_7 = (i % 10) < 5;
      @(negedge ck);
      if (ovr_7 === 1'b1 && set_at < 0) set_at = i;
      if (set_at >= 0 && ovr_7 !== 1'b1) dropped++;
      if (co5_7 === 1'b1 && co10_7 === 1'b1) both++;
    end
    raw5_7  = 1'b0;
    raw10_7 = 1'b0;
    n_cmp++;
    if (set_at < 0 || dropped != 0) begin
      n_err++;
      $display("FAIL ovr_sticky set_at=%0d dropped=%0d exp set and held", set_at, dropped);
    end
    n_cmp++;
    if (both != 0) begin
      n_err++;
      $display("FAIL ovr_exclusive overlaps=%0d exp=0", both);
    end
    @(negedge ck);
    reset = 1'b0;
    @(negedge ck);
    n_cmp++;
    if (ovr_7 !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear got=%b exp=0", ovr_7);
    end
    reset = 1'b1;
  endtask

  task automatic test_random();
    int hold[3] = '{1, 1, 1};
    int both = 0;
    for (int i = 0; i < 900; i++) begin
      for (int s = 0; s < 3; s++) begin
        hold[s]--;
        if (hold[s] <= 0) begin
          hold[s] = int'($urandom_range(1, 14));
          case (s)
            0: raw5 = ~raw5;
            1: raw10 = ~raw10;
            default: rawpay = ~rawpay;
          endcase
        end
      end
      @(negedge ck);
      n_cmp++;
      if ({co5, co10, pay, busy, ovr} !== m_exp) begin
        n_err++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", i, {co5, co10, pay, busy, ovr}, m_exp);
      end
      if (int'(co5) + int'(co10) + int'(pay) > 1) both++;
    end
    n_cmp++;
    if (both != 0) begin
      n_err++;
      $display("FAIL random_exclusive overlaps=%0d exp=0", both);
    end
  endtask

  initial begin
    reset    = 1'b1;
    raw5     = 1'b0;
    raw10    = 1'b0;
    rawpay   = 1'b0;
    raw5_7   = 1'b0;
    raw10_7  = 1'b0;
    rawpay_7 = 1'b0;
    #5 reset = 1'b0;
    test_reset();
    test_release_latency();
    test_bounce();
    test_simultaneous();
    test_sequence();
    test_reset_abort();
    test_overrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DB_CYC, default 4: consecutive cycles a synchronized raw input must differ from its debounced level before the debounced level changes (legal 2..15).
REQ-002 Parameter GAP, default 2: minimum idle cycles between two output pulses (legal 1..7).
REQ-003 ck  input  1  system clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 raw5  input  1  mechanical 5-unit coin switch, asynchronous, may bounce.
REQ-006 raw10  input  1  mechanical 10-unit coin switch, asynchronous, may bounce.
REQ-007 rawpay  input  1  mechanical pay button, asynchronous, may bounce.
REQ-008 co5  output  1  one-cycle pulse per accepted 5-unit coin, to vending core co5.
REQ-009 co10  output  1  one-cycle pulse per accepted 10-unit coin, to vending core co10.
REQ-010 pay  output  1  one-cycle pulse per accepted pay press, to vending core pay.
REQ-011 busy  output  1  high while any event is pending or the issuer is not IDLE.
REQ-012 ovr  output  1  sticky flag: an event was lost because its source was already pending.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Per source, a 4-bit counter SHALL increment while synchronized value != debounced value and clear to 0 on any cycle they are equal.
REQ-015 Debounced value SHALL take the synchronized value on the cycle the counter would reach DB_CYC; the counter then clears.
REQ-016 A bounce shorter than DB_CYC cycles SHALL cause no debounced change and no pulse.
REQ-017 A debounced 0->1 transition SHALL set that source's pending flag on the next edge; 1->0 transitions generate nothing.
REQ-018 If a rising edge arrives while that source is already pending and not being issued in the same cycle, the event SHALL be dropped and ovr set to 1.
REQ-019 Issuer FSM states: IDLE, PULSE, GAP.
REQ-020 IDLE: if any pending flag set, select by fixed priority co5 > co10 > pay, go to PULSE; else stay.
REQ-021 PULSE (exactly one cycle): assert only the selected output, clear its pending flag, load gap counter with GAP, go to GAP.
REQ-022 GAP: all outputs low; decrement gap counter; go to IDLE on the cycle it reaches 0.
REQ-023 co5, co10, pay SHALL never be high in the same cycle and each high for exactly one cycle per event.
REQ-024 Latency with issuer in IDLE: raw level stable from edge N -> output pulse high during cycle N+DB_CYC+4 (8 with defaults).
REQ-025 Pending set and issue of the same source in one cycle: the new edge SHALL remain pending (not lost, no ovr).
REQ-026 Pulse spacing SHALL be exactly GAP+1 cycles start-to-start when back-to-back events are pending.
REQ-027 busy = OR(pending flags) OR (state != IDLE), combinational from registers.

Reset
REQ-028 reset low SHALL immediately clear synchronizers, debounced values, counters, pending flags, ovr, and force IDLE.
REQ-029 During reset co5=co10=pay=0, busy=0, ovr=0.
REQ-030 Reset asserted mid-PULSE or mid-GAP SHALL abort it; pending events are discarded, no pulse after release.
REQ-031 A raw input already high at reset release SHALL produce one pulse after DB_CYC+4 cycles (debounced starts at 0).

Verification (20 ns clock, defaults)
REQ-032 reset low 100 ns, raw5 high 100 ns -> co5 single pulse 8 cycles after raw5 rises; co10=pay=0; busy high until GAP ends.
REQ-033 raw10 toggles every cycle for 3 cycles then stays low -> no co10 pulse, ovr=0.
REQ-034 raw5 and raw10 rise same cycle -> co5 pulse, then co10 pulse exactly 3 cycles later.
REQ-035 Sequence raw5, raw10, raw10, rawpay each high 100 ns with 100 ns gaps -> pulses co5, co10, co10, pay in order, one each.
REQ-036 raw10 clean pulses 5 cycles high/5 low while GAP forced to 7 and raw5 held pending -> ovr rises to 1 and stays until reset.
REQ-037 reset low during GAP after co5 with co10 pending -> no co10 pulse after release, busy=0.
